// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: a latency-matched multiplier and a radix-2 restoring divider
// behind one valid/ready request port and one valid/ready result port.
module muldiv_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  busy_o,
  output logic [1:0]            dbg_state_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + MUL_LATENCY + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  // Handshake: a request moves on a rising edge where valid_i & ready_o, a result
  // moves on a rising edge where valid_o & ready_i; flush_i overrides both.
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  res_q, res_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;

  // Request decode: signed divide ops are div/rem (op_i[0] clear).
  logic         div_signed;
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  assign div_signed = ~op_i[0];
  assign a_neg      = div_signed & a_i[W-1];
  assign b_neg      = div_signed & b_i[W-1];
  assign a_mag      = a_neg ? -a_i : a_i;
  assign b_mag      = b_neg ? -b_i : b_i;

  // op_q: 00 mul, 01 mulh (s*s), 10 mulhsu (s*u), 11 mulhu (u*u).
  logic           a_sgn, b_sgn;
  logic [2*W-1:0] a_ext, b_ext, prod;
  logic [W-1:0]   mul_res;

  assign a_sgn   = (op_q == 2'b01) || (op_q == 2'b10);
  assign b_sgn   = (op_q == 2'b01);
  assign a_ext   = {{W{a_sgn & a_q[W-1]}}, a_q};
  assign b_ext   = {{W{b_sgn & b_q[W-1]}}, b_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op_q == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];

  // One restoring step: a_q shifts dividend bits out MSB-first and quotient bits in.
  logic [W:0]   r_shift, r_diff;
  logic         r_ge;
  logic [W-1:0] r_next, q_next, r_fix, q_fix;

  assign r_shift = {rem_q, a_q[W-1]};
  assign r_diff  = r_shift - {1'b0, b_q};
  assign r_ge    = ~r_diff[W];
  assign r_next  = r_ge ? r_diff[W-1:0] : r_shift[W-1:0];
  assign q_next  = {a_q[W-2:0], r_ge};
  assign q_fix   = negq_q ? -q_next : q_next;
  assign r_fix   = negr_q ? -r_next : r_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    res_d   = res_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            op_d   = op_i[1:0];
            a_d    = a_i;
            b_d    = b_i;
            rem_d  = '0;
            negq_d = 1'b0;
            negr_d = 1'b0;
            if (!op_i[2]) begin
              state_d = S_MUL;
              cnt_d   = CW'(MUL_LATENCY - 1);
            end else if (b_i == '0) begin
              state_d = S_DONE;
              res_d   = op_i[1] ? a_i : '1;
            end else if (div_signed && (a_i == MIN_INT) && (b_i == '1)) begin
              state_d = S_DONE;
              res_d   = op_i[1] ? '0 : MIN_INT;
            end else begin
              state_d = S_DIV;
              cnt_d   = CW'(W - 1);
              a_d     = a_mag;
              b_d     = b_mag;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            res_d   = mul_res;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DIV: begin
          a_d   = q_next;
          rem_d = r_next;
          if (cnt_q == '0) begin
            res_d   = op_q[1] ? r_fix : q_fix;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          if (ready_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign ready_o     = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign valid_o     = (state_q == S_DONE);
  assign res_o       = res_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, result hold, flush, async reset, random ops.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic         ready_o;
  logic [2:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         flush_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] res_o;
  logic         busy_o;
  logic [1:0]   dbg_state_o;

  // Clock / reset
  always #5 clk_i = ~clk_i;

  muldiv_unit #(.DATA_WIDTH(W), .MUL_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .res_o(res_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [W-1:0] last_res;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model from the RV32M definitions.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sb, ub;
    logic [63:0]  p;
    int           ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles after the accept edge until valid_o; special divides finish at the accept edge itself.
  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!op[2]) return LAT;
    if (b == 0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return W;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    if (!ready_o) check("issue_ready_timeout", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    if (track) begin
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(exp_lat(op, a, b));
    end
    tick();
    valid_i = 1'b0;
    op_i    = 3'($urandom_range(0, 7));
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic collect(input string tag);
    int cycles;
    logic [W-1:0] e;
    int l;
    cycles = 0;
    while (!valid_o && cycles < 200) begin
      tick();
      cycles++;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (!valid_o) begin
      check({tag, "_timeout"}, 32'(valid_o), 32'd1);
    end else begin
      check(tag, res_o, e);
      check({tag, "_lat"}, 32'(cycles), 32'(l));
      last_res = e;
    end
    tick();
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    issue(op, a, b, 1'b1);
    collect(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int vcount;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    last_res = '0;
    #12;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_res", res_o, 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'd0);
    #1 rst_ni = 1'b1;
    tick();

    run(3'd0, 32'hFFFF_FFF9, 32'd3,          "mul_neg7x3");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  "mulhu_max");
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  "mulhsu_max");
    run(3'd1, 32'h8000_0000, 32'h8000_0000,  "mulh_min");
    run(3'd4, 32'hFFFF_FFF9, 32'd2,          "div_neg7_2");
    run(3'd6, 32'hFFFF_FFF9, 32'd2,          "rem_neg7_2");
    run(3'd5, 32'd100,       32'd0,          "divu_by0");
    run(3'd7, 32'd100,       32'd0,          "remu_by0");
    run(3'd4, 32'd55,        32'd0,          "div_by0");
    run(3'd6, 32'hFFFF_FF00, 32'd0,          "rem_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  "rem_ovf");
    run(3'd4, 32'd7,         32'hFFFF_FFFE,  "div_pos_neg");
    run(3'd6, 32'd7,         32'hFFFF_FFFE,  "rem_pos_neg");
    run(3'd5, 32'h8000_0000, 32'd1,          "divu_min_1");

    // Result held while the consumer stalls
    ready_i = 1'b0;
    issue(3'd5, 32'd1000, 32'd7, 1'b1);
    collect("divu_hold");
    for (int i = 0; i < 5; i++) begin
      check("hold_res", res_o, 32'd142);
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_ready", 32'(ready_o), 32'd0);
      tick();
    end
    ready_i = 1'b1;
    tick();
    check("hold_release_valid", 32'(valid_o), 32'd0);
    check("hold_release_ready", 32'(ready_o), 32'd1);

    // Flush in the middle of a divide
    issue(3'd4, 32'd12345, 32'd67, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check("flush_pre_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_ready", 32'(ready_o), 32'd1);
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_res_kept", res_o, last_res);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) vcount++;
      tick();
    end
    check("flush_no_valid", 32'(vcount), 32'd0);

    // Flush together with a request in IDLE: not accepted
    valid_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 3'd0;
    a_i     = 32'd9;
    b_i     = 32'd9;
    tick();
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_idle_busy", 32'(busy_o), 32'd0);
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_o) vcount++;
      tick();
    end
    check("flush_idle_no_valid", 32'(vcount), 32'd0);

    // Random operations, some with zero or minus-one divisors
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 50));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run(rop, ra, rb, "rand");
    end

    // Asynchronous reset in the middle of a multiply
    issue(3'd0, 32'd5, 32'd6, 1'b0);
    check("mid_mul_busy", 32'(busy_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_res", res_o, 32'd0);
    check("arst_ready", 32'(ready_o), 32'd1);
    check("arst_busy", 32'(busy_o), 32'd0);
    #2 rst_ni = 1'b1;
    tick();
    run(3'd0, 32'd5, 32'd6, "post_rst_mul");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
